// File: rtl/alu_issue_ctrl_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : alu_issue_ctrl_if                                        |
// | Description : Request, ALU operand/select and response signals of the  |
// |               ALU issue controller, bundled with controller (master)   |
// |               and environment (slave) views.                           |
// | Revision    : 1.0  initial release                                     |
// +------------------------------------------------------------------------+
interface alu_issue_ctrl_if;
  // request channel
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_funct3;
  logic [6:0]  req_funct7;
  logic        req_is_imm;
  logic [31:0] req_a;
  logic [31:0] req_b;
  // combinational ALU
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [3:0]  alu_sel;
  logic [31:0] alu_out;
  logic        alu_carry;
  // response channel
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_result;
  logic        rsp_carry;
  logic        rsp_zero;
  logic        rsp_illegal;

  modport master (
    input  req_valid, req_funct3, req_funct7, req_is_imm, req_a, req_b,
    input  alu_out, alu_carry, rsp_ready,
    output req_ready, alu_a, alu_b, alu_sel,
    output rsp_valid, rsp_result, rsp_carry, rsp_zero, rsp_illegal
  );

  modport slave (
    output req_valid, req_funct3, req_funct7, req_is_imm, req_a, req_b,
    output alu_out, alu_carry, rsp_ready,
    input  req_ready, alu_a, alu_b, alu_sel,
    input  rsp_valid, rsp_result, rsp_carry, rsp_zero, rsp_illegal
  );
endinterface
`default_nettype wire

// File: rtl/alu_issue_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : alu_issue_ctrl                                           |
// | Description : Initiator of the 32-bit ALU operand/select interface.    |
// |               Decodes RV32I/M funct3/funct7 to an ALU select, holds    |
// |               registered operands for a settle window, iterates the    |
// |               shift-by-1 ops for SLL/SRL and returns the result over   |
// |               a valid/ready response channel.                          |
// |               Optional macro MULDIV_EN enables MUL/DIV decode.         |
// | Revision    : 1.0  initial release                                     |
// +------------------------------------------------------------------------+
module alu_issue_ctrl #(
  parameter int SETTLE_CYCLES = 1,
  parameter int MULDIV_SETTLE = 4
) (
  input  logic             clk,
  input  logic             rst,
  alu_issue_ctrl_if.master bus
);

  localparam logic [3:0] c_SEL_ADD  = 4'b0000;
  localparam logic [3:0] c_SEL_SUB  = 4'b0001;
`ifdef MULDIV_EN
  localparam logic [3:0] c_SEL_MUL  = 4'b0010;
  localparam logic [3:0] c_SEL_DIV  = 4'b0011;
`endif
  localparam logic [3:0] c_SEL_SLL1 = 4'b0100;
  localparam logic [3:0] c_SEL_SRL1 = 4'b0101;
  localparam logic [3:0] c_SEL_AND  = 4'b1000;
  localparam logic [3:0] c_SEL_OR   = 4'b1001;
  localparam logic [3:0] c_SEL_XOR  = 4'b1010;
  localparam logic [3:0] c_SEL_SLTU = 4'b1101;
  localparam logic [3:0] c_SEL_SLT  = 4'b1110;
  localparam logic [3:0] c_SEL_SRA  = 4'b1111;

  // Counter must cover both settle windows and the largest shift amount.
  localparam int c_SET_MAX = (SETTLE_CYCLES > MULDIV_SETTLE) ? SETTLE_CYCLES : MULDIV_SETTLE;
  localparam int c_CNT_MAX = (c_SET_MAX > 31) ? c_SET_MAX : 31;
  localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);
  localparam logic [c_CNT_W-1:0] c_CNT_SETTLE = c_CNT_W'(SETTLE_CYCLES);
  localparam logic [c_CNT_W-1:0] c_CNT_MULDIV = c_CNT_W'(MULDIV_SETTLE);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_EXEC  = 2'd1,
    S_SHIFT = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [31:0]          r_alu_a;
  logic [31:0]          r_alu_b;
  logic [3:0]           r_alu_sel;
  logic [c_CNT_W-1:0]   r_cnt;
  logic [31:0]          r_result;
  logic                 r_carry;
  logic                 r_zero;
  logic                 r_illegal;

  logic [3:0]           w_sel;
  logic                 w_illegal;
  logic                 w_muldiv;
  logic                 w_div0;
  logic                 w_is_shift;
  logic                 w_shift0;
  logic [4:0]           w_shamt;
  logic                 w_f7_zero;
  logic                 w_f7_alt;
  logic                 w_f7_md;
  logic                 w_rtype_bad;
  logic                 w_accept;
  logic                 w_cnt_last;
  logic [c_CNT_W-1:0]   w_settle;

  assign w_shamt     = bus.req_b[4:0];
  assign w_f7_zero   = (bus.req_funct7 == 7'b0000000);
  assign w_f7_alt    = (bus.req_funct7 == 7'b0100000);
  assign w_f7_md     = (bus.req_funct7 == 7'b0000001);
  assign w_rtype_bad = !bus.req_is_imm && !w_f7_zero;
  assign w_is_shift  = !w_illegal && ((w_sel == c_SEL_SLL1) || (w_sel == c_SEL_SRL1));
  assign w_shift0    = w_is_shift && (w_shamt == 5'd0);
  assign w_settle    = w_muldiv ? c_CNT_MULDIV : c_CNT_SETTLE;
  assign w_accept    = bus.req_valid && bus.req_ready;
  assign w_cnt_last  = (r_cnt <= c_CNT_W'(1));

  assign bus.req_ready   = (r_state == S_IDLE) && !rst;
  assign bus.alu_a       = r_alu_a;
  assign bus.alu_b       = r_alu_b;
  assign bus.alu_sel     = r_alu_sel;
  assign bus.rsp_valid   = (r_state == S_RESP);
  assign bus.rsp_result  = r_result;
  assign bus.rsp_carry   = r_carry;
  assign bus.rsp_zero    = r_zero;
  assign bus.rsp_illegal = r_illegal;

  // Decode funct3/funct7/is_imm of the presented request into select and shortcut flags.
  always_comb begin
    w_sel     = c_SEL_ADD;
    w_illegal = 1'b0;
    w_muldiv  = 1'b0;
    w_div0    = 1'b0;
    if (!bus.req_is_imm && w_f7_md) begin
`ifdef MULDIV_EN
      w_muldiv = 1'b1;
      case (bus.req_funct3)
        3'b000:  w_sel = c_SEL_MUL;
        3'b100: begin
          w_sel  = c_SEL_DIV;
          w_div0 = (bus.req_b == 32'd0);
        end
        default: w_illegal = 1'b1;
      endcase
`else
      w_illegal = 1'b1;
`endif
    end else begin
      case (bus.req_funct3)
        3'b000: begin
          if (bus.req_is_imm || w_f7_zero) w_sel = c_SEL_ADD;
          else if (w_f7_alt)               w_sel = c_SEL_SUB;
          else                             w_illegal = 1'b1;
        end
        3'b001: begin
          w_sel     = c_SEL_SLL1;
          w_illegal = !w_f7_zero;
        end
        3'b010: begin
          w_sel     = c_SEL_SLT;
          w_illegal = w_rtype_bad;
        end
        3'b011: begin
          w_sel     = c_SEL_SLTU;
          w_illegal = w_rtype_bad;
        end
        3'b100: begin
          w_sel     = c_SEL_XOR;
          w_illegal = w_rtype_bad;
        end
        3'b101: begin
          if (w_f7_zero)     w_sel = c_SEL_SRL1;
          else if (w_f7_alt) w_sel = c_SEL_SRA;
          else               w_illegal = 1'b1;
        end
        3'b110: begin
          w_sel     = c_SEL_OR;
          w_illegal = w_rtype_bad;
        end
        default: begin
          w_sel     = c_SEL_AND;
          w_illegal = w_rtype_bad;
        end
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state: shortcuts go straight to RESP, ALU ops wait out their counter.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_illegal || w_div0 || w_shift0) w_state_nxt = S_RESP;
          else if (w_is_shift)                 w_state_nxt = S_SHIFT;
          else                                 w_state_nxt = S_EXEC;
        end
      end
      S_EXEC, S_SHIFT: begin
        if (w_cnt_last) w_state_nxt = S_RESP;
      end
      S_RESP: begin
        if (bus.rsp_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Operand, counter and response registers; shortcut paths leave the ALU inputs untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_alu_a   <= '0;
      r_alu_b   <= '0;
      r_alu_sel <= '0;
      r_cnt     <= '0;
      r_result  <= '0;
      r_carry   <= 1'b0;
      r_zero    <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (w_illegal) begin
              r_result  <= '0;
              r_carry   <= 1'b0;
              r_zero    <= 1'b1;
              r_illegal <= 1'b1;
            end else if (w_div0) begin
              r_result  <= '1;
              r_carry   <= 1'b0;
              r_zero    <= 1'b0;
              r_illegal <= 1'b0;
            end else if (w_shift0) begin
              r_result  <= bus.req_a;
              r_carry   <= 1'b0;
              r_zero    <= (bus.req_a == 32'd0);
              r_illegal <= 1'b0;
            end else begin
              r_alu_a   <= bus.req_a;
              r_alu_sel <= w_sel;
              r_illegal <= 1'b0;
              if (w_is_shift) begin
                r_alu_b <= '0;
                r_cnt   <= c_CNT_W'(w_shamt);
              end else begin
                // SRA is a single-step barrel op: only the shift amount is meaningful.
                r_alu_b <= (w_sel == c_SEL_SRA) ? {27'd0, w_shamt} : bus.req_b;
                r_cnt   <= w_settle;
              end
            end
          end
        end
        S_EXEC: begin
          r_cnt <= r_cnt - 1'b1;
          if (w_cnt_last) begin
            r_result <= bus.alu_out;
            r_carry  <= bus.alu_carry;
            r_zero   <= (bus.alu_out == 32'd0);
          end
        end
        S_SHIFT: begin
          r_alu_a <= bus.alu_out;
          r_cnt   <= r_cnt - 1'b1;
          if (w_cnt_last) begin
            r_result <= bus.alu_out;
            r_carry  <= 1'b0;
            r_zero   <= (bus.alu_out == 32'd0);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : tb_alu_issue_ctrl                                        |
// | Description : Self-checking bench for alu_issue_ctrl with a settle-    |
// |               aware ALU model and an RV32I/M reference model.          |
// | Revision    : 1.0  initial release                                     |
// +------------------------------------------------------------------------+
module tb_alu_issue_ctrl;

  localparam int SETTLE = 1;
  localparam int MD     = 4;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  alu_issue_ctrl_if bus();

  alu_issue_ctrl #(.SETTLE_CYCLES(SETTLE), .MULDIV_SETTLE(MD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  // ---------------- ALU model: returns garbage until inputs settled ----------------
  logic [31:0] m_pa = '0, m_pb = '0;
  logic [3:0]  m_ps = '0;
  int          m_age = 0;
  logic [32:0] m_alu;
  logic        saw_md_sel = 1'b0;

  function automatic logic [32:0] alu_fn(input logic [3:0] s, input logic [31:0] a, input logic [31:0] b);
    case (s)
      4'h0: return {1'b0, a} + {1'b0, b};
      4'h1: return {1'b0, a} - {1'b0, b};
      4'h2: return {1'b0, a * b};
      4'h3: return (b == 32'd0) ? {1'b0, 32'hFFFF_FFFF} : {1'b0, $signed(a) / $signed(b)};
      4'h4: return {a[31], a << 1};
      4'h5: return {a[0], a >> 1};
      4'h8: return {1'b0, a & b};
      4'h9: return {1'b0, a | b};
      4'hA: return {1'b0, a ^ b};
      4'hD: return {32'd0, a < b};
      4'hE: return {32'd0, $signed(a) < $signed(b)};
      4'hF: return {1'b0, $signed(a) >>> b[4:0]};
      default: return 33'd0;
    endcase
  endfunction

  always @(negedge clk) begin
    if (bus.alu_a !== m_pa || bus.alu_b !== m_pb || bus.alu_sel !== m_ps) m_age <= 1;
    else if (m_age < 1000) m_age <= m_age + 1;
    m_pa <= bus.alu_a;
    m_pb <= bus.alu_b;
    m_ps <= bus.alu_sel;
    if (bus.alu_sel == 4'h2 || bus.alu_sel == 4'h3) saw_md_sel <= 1'b1;
  end

  always_comb begin
    m_alu = {1'b1, 32'hBAD0_BAD0};
    if (m_age >= (((bus.alu_sel == 4'h2) || (bus.alu_sel == 4'h3)) ? MD : SETTLE))
      m_alu = alu_fn(bus.alu_sel, bus.alu_a, bus.alu_b);
  end
  assign bus.alu_carry = m_alu[32];
  assign bus.alu_out   = m_alu[31:0];

  // ---------------- reference model: RISC-V semantics ----------------
  task automatic ref_model(input logic [2:0] f3, input logic [6:0] f7, input logic imm,
                           input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] res, output logic c, output logic ill,
                           output int lat, output logic [3:0] sel, output logic drv);
    logic       r;
    logic [4:0] sh;
    r = !imm; sh = b[4:0];
    res = '0; c = 1'b0; ill = 1'b0; lat = SETTLE; sel = 4'h0; drv = 1'b1;
    if (r && f7 == 7'h01) begin
`ifdef MULDIV_EN
      if (f3 == 3'd0) begin res = a * b; lat = MD; sel = 4'h2; end
      else if (f3 == 3'd4) begin
        sel = 4'h3; lat = MD;
        if (b == 0) begin res = 32'hFFFF_FFFF; lat = 0; drv = 1'b0; end
        else res = $signed(a) / $signed(b);
      end else ill = 1'b1;
`else
      ill = 1'b1;
`endif
    end else begin
      case (f3)
        3'd0: if (!r || f7 == 0) begin {c, res} = {1'b0, a} + {1'b0, b}; sel = 4'h0; end
              else if (f7 == 7'h20) begin {c, res} = {1'b0, a} - {1'b0, b}; sel = 4'h1; end
              else ill = 1'b1;
        3'd1: if (f7 != 0) ill = 1'b1;
              else begin res = a << sh; lat = sh; sel = 4'h4; end
        3'd2: begin ill = r && f7 != 0; res = {31'd0, $signed(a) < $signed(b)}; sel = 4'hE; end
        3'd3: begin ill = r && f7 != 0; res = {31'd0, a < b}; sel = 4'hD; end
        3'd4: begin ill = r && f7 != 0; res = a ^ b; sel = 4'hA; end
        3'd5: if (f7 == 0) begin res = a >> sh; lat = sh; sel = 4'h5; end
              else if (f7 == 7'h20) begin res = $signed(a) >>> sh; sel = 4'hF; end
              else ill = 1'b1;
        3'd6: begin ill = r && f7 != 0; res = a | b; sel = 4'h9; end
        default: begin ill = r && f7 != 0; res = a & b; sel = 4'h8; end
      endcase
      if ((sel == 4'h4 || sel == 4'h5) && !ill && sh == 0) begin res = a; lat = 0; drv = 1'b0; end
    end
    if (ill) begin res = '0; c = 1'b0; lat = 0; drv = 1'b0; end
  endtask

  // ---------------- one full transaction with inline checks ----------------
  task automatic run_op(input string tag, input logic [2:0] f3, input logic [6:0] f7, input logic imm,
                        input logic [31:0] a, input logic [31:0] b, input int hold);
    logic [31:0] e_res;
    logic        e_c, e_ill, e_drv;
    int          e_lat, lat;
    logic [3:0]  e_sel, pre_sel;
    ref_model(f3, f7, imm, a, b, e_res, e_c, e_ill, e_lat, e_sel, e_drv);
    pre_sel = bus.alu_sel;
    bus.req_funct3 = f3; bus.req_funct7 = f7; bus.req_is_imm = imm;
    bus.req_a = a; bus.req_b = b; bus.req_valid = 1'b1;
    lat = 0;
    while (!bus.req_ready && lat < 50) begin @(posedge clk); #1; lat++; end
    if (!bus.req_ready) begin
      n_checks++;
      $display("FAIL %s accept: req_ready stuck at %b, required 1", tag, bus.req_ready);
      bus.req_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    n_checks++;
    if (bus.alu_sel !== (e_drv ? e_sel : pre_sel))
      $display("FAIL %s alu_sel: got %h required %h", tag, bus.alu_sel, e_drv ? e_sel : pre_sel);
    else n_pass++;
    lat = 0;
    while (!bus.rsp_valid && lat < 100) begin @(posedge clk); #1; lat++; end
    n_checks++;
    if (lat !== e_lat) $display("FAIL %s latency: got %0d required %0d", tag, lat, e_lat);
    else n_pass++;
    n_checks++;
    if (bus.rsp_result !== e_res) $display("FAIL %s result: got %h required %h", tag, bus.rsp_result, e_res);
    else n_pass++;
    n_checks++;
    if ({bus.rsp_carry, bus.rsp_zero, bus.rsp_illegal} !== {e_c, e_res == 0, e_ill})
      $display("FAIL %s flags c/z/ill: got %b%b%b required %b%b%b", tag, bus.rsp_carry, bus.rsp_zero,
               bus.rsp_illegal, e_c, e_res == 0, e_ill);
    else n_pass++;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_result !== e_res)
        $display("FAIL %s hold: got valid=%b result=%h required valid=1 result=%h", tag, bus.rsp_valid,
                 bus.rsp_result, e_res);
      else n_pass++;
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    n_checks++;
    if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1)
      $display("FAIL %s release: got rsp_valid=%b req_ready=%b required 0/1", tag, bus.rsp_valid, bus.req_ready);
    else n_pass++;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    bus.req_valid = 1'b0; bus.req_funct3 = '0; bus.req_funct7 = '0; bus.req_is_imm = 1'b0;
    bus.req_a = '0; bus.req_b = '0; bus.rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({bus.req_ready, bus.rsp_valid, bus.alu_a, bus.alu_b, bus.alu_sel} !== '0)
      $display("FAIL reset alu/handshake: got rr=%b rv=%b a=%h b=%h sel=%h required all 0", bus.req_ready,
               bus.rsp_valid, bus.alu_a, bus.alu_b, bus.alu_sel);
    else n_pass++;
    n_checks++;
    if ({bus.rsp_result, bus.rsp_carry, bus.rsp_illegal} !== '0)
      $display("FAIL reset rsp: got result=%h c=%b ill=%b required 0", bus.rsp_result, bus.rsp_carry, bus.rsp_illegal);
    else n_pass++;
    rst = 1'b0;
    #1;
    n_checks++;
    if (bus.req_ready !== 1'b1) $display("FAIL reset release req_ready: got %b required 1", bus.req_ready);
    else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_add_sub();
    run_op("add_5_7",    3'd0, 7'h00, 1'b0, 32'd5, 32'd7, 0);
    run_op("sub_3_5",    3'd0, 7'h20, 1'b0, 32'd3, 32'd5, 1);
    run_op("sub_9_9",    3'd0, 7'h20, 1'b0, 32'd9, 32'd9, 0);
    run_op("addi_carry", 3'd0, 7'h7F, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFF0, 0);
    run_op("sra_neg",    3'd5, 7'h20, 1'b1, 32'h8000_0010, 32'd4, 0);
  endtask

  task automatic test_shift();
    run_op("sll_1_37",   3'd1, 7'h00, 1'b0, 32'd1, 32'd37, 0);
    run_op("srl_max",    3'd5, 7'h00, 1'b1, 32'hFFFF_FFFF, 32'd31, 0);
    run_op("sll_zero",   3'd1, 7'h00, 1'b0, 32'h1234_5678, 32'd32, 0);
    run_op("slli_bad",   3'd1, 7'h20, 1'b1, 32'd1, 32'd3, 0);
  endtask

  task automatic test_div();
    run_op("xor_pre",    3'd4, 7'h00, 1'b0, 32'hF0F0_0000, 32'h0FF0_1234, 0);
    run_op("div_10_0",   3'd4, 7'h01, 1'b0, 32'd10, 32'd0, 0);
    run_op("mul_6_7",    3'd0, 7'h01, 1'b0, 32'd6, 32'd7, 0);
    run_op("div_m20_3",  3'd4, 7'h01, 1'b0, 32'hFFFF_FFEC, 32'd3, 0);
    run_op("md_bad_f3",  3'd2, 7'h01, 1'b0, 32'd6, 32'd7, 0);
  endtask

  task automatic test_backpressure();
    logic [31:0] a, b, e;
    int          t;
    a = $urandom; b = $urandom; e = a + b;
    bus.req_funct3 = 3'd0; bus.req_funct7 = 7'h00; bus.req_is_imm = 1'b0;
    bus.req_a = a; bus.req_b = b; bus.req_valid = 1'b1;
    @(posedge clk); #1;
    bus.req_a = 32'd1; bus.req_b = 32'd1;  // next request stays pending
    t = 0;
    while (!bus.rsp_valid && t < 20) begin @(posedge clk); #1; t++; end
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_result !== e || bus.req_ready !== 1'b0)
        $display("FAIL backpressure hold %0d: got rv=%b res=%h rr=%b required 1/%h/0", i, bus.rsp_valid,
                 bus.rsp_result, bus.req_ready, e);
      else n_pass++;
      @(posedge clk); #1;
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    n_checks++;
    if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1)
      $display("FAIL backpressure release: got rv=%b rr=%b required 0/1", bus.rsp_valid, bus.req_ready);
    else n_pass++;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    n_checks++;
    if (bus.req_ready !== 1'b0) $display("FAIL backpressure next accept: got rr=%b required 0", bus.req_ready);
    else n_pass++;
    t = 0;
    while (!bus.rsp_valid && t < 20) begin @(posedge clk); #1; t++; end
    n_checks++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_result !== 32'd2)
      $display("FAIL backpressure second: got rv=%b res=%h required 1/00000002", bus.rsp_valid, bus.rsp_result);
    else n_pass++;
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_reset_mid_shift();
    logic saw;
    bus.req_funct3 = 3'd1; bus.req_funct7 = 7'h00; bus.req_is_imm = 1'b0;
    bus.req_a = $urandom | 32'h1; bus.req_b = 32'd20; bus.req_valid = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({bus.req_ready, bus.alu_a, bus.alu_b, bus.alu_sel} !== '0)
      $display("FAIL midreset alu: got rr=%b a=%h b=%h sel=%h required 0", bus.req_ready, bus.alu_a,
               bus.alu_b, bus.alu_sel);
    else n_pass++;
    n_checks++;
    if ({bus.rsp_valid, bus.rsp_result, bus.rsp_carry, bus.rsp_zero, bus.rsp_illegal} !== '0)
      $display("FAIL midreset rsp: got rv=%b res=%h c=%b z=%b ill=%b required 0", bus.rsp_valid,
               bus.rsp_result, bus.rsp_carry, bus.rsp_zero, bus.rsp_illegal);
    else n_pass++;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    saw = 1'b0;
    repeat (30) begin @(posedge clk); #1; if (bus.rsp_valid) saw = 1'b1; end
    n_checks++;
    if (saw !== 1'b0) $display("FAIL midreset stray response: got %b required 0", saw);
    else n_pass++;
    run_op("add_after_rst", 3'd0, 7'h00, 1'b0, 32'd100, 32'd23, 0);
  endtask

  task automatic test_random();
    logic [6:0]  f7;
    logic [31:0] a, b;
    for (int i = 0; i < 80; i++) begin
      case ($urandom_range(0, 5))
        0, 1, 2: f7 = 7'h00;
        3:       f7 = 7'h20;
        4:       f7 = 7'h01;
        default: f7 = 7'($urandom);
      endcase
      a = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      b = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 40)) : $urandom;
      run_op("random", 3'($urandom_range(0, 7)), f7, 1'($urandom_range(0, 1)), a, b, $urandom_range(0, 2));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_add_sub();
    test_shift();
    test_div();
    test_backpressure();
    test_reset_mid_shift();
    test_random();
`ifndef MULDIV_EN
    n_checks++;
    if (saw_md_sel !== 1'b0) $display("FAIL muldiv select seen: got %b required 0", saw_md_sel);
    else n_pass++;
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Initiator side of the 32-bit ALU operand/select interface in the CGRA processing element.
- Accepts one decoded RV32I/M arithmetic op per handshake and maps funct3/funct7 to the 4-bit ALU select code.
- Drives registered operands to the combinational ALU and holds them for a programmable settle window, so mul/div can be multicycle paths.
- Iterates the ALU's shift-by-1 ops for SLL/SRL, then returns the result over a valid/ready response channel.

Parameters:
SETTLE_CYCLES, 1, cycles ALU inputs are held before sampling alu_out for non-mul/div ops (min 1)
MULDIV_SETTLE, 4, cycles held before sampling for MUL/DIV (min 1)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
req_valid  in  1  request valid
req_ready  out  1  request accepted when valid&&ready
req_funct3  in  3  RISC-V funct3
req_funct7  in  7  RISC-V funct7 (ignored for I-type except shifts)
req_is_imm  in  1  1 = OP-IMM (b is sign-extended immediate)
req_a  in  32  rs1 value
req_b  in  32  rs2 value or immediate
alu_a  out  32  ALU operand A (registered)
alu_b  out  32  ALU operand B (registered)
alu_sel  out  4  ALU select (registered)
alu_out  in  32  ALU result
alu_carry  in  1  ALU carry-out
rsp_valid  out  1  response valid
rsp_ready  in  1  response consumed when valid&&ready
rsp_result  out  32  result
rsp_carry  out  1  captured alu_carry (0 for shortcut paths)
rsp_zero  out  1  rsp_result == 0
rsp_illegal  out  1  op not supported, rsp_result = 0

Behaviour:
- Reset: state IDLE; alu_a/alu_b/alu_sel = 0; rsp_valid, rsp_result, rsp_carry, rsp_illegal = 0; req_ready = 0 while rst high.
- Reset asserted mid-op abandons the op; no response is produced.
- Select codes:
  - ADD 0000, SUB 0001, MUL 0010, DIV 0011
  - SLL1 0100, SRL1 0101
  - AND 1000, OR 1001, XOR 1010
  - SLTU 1101, SLT 1110, SRA 1111
- Decode by funct3:
  - 000: ADD; SUB if !is_imm and funct7=0100000
  - 001: SLL (funct7 must be 0)
  - 010: SLT
  - 011: SLTU
  - 100: XOR
  - 101: SRL if funct7=0, SRA if funct7=0100000
  - 110: OR
  - 111: AND
- R-type with funct7=0000001: funct3 000 = MUL, 100 = DIV; other funct3 values are illegal.
- Any other funct7 on R-type, or on I-type shifts, is illegal.
- States: IDLE, EXEC, SHIFT, RESP. req_ready=1 only in IDLE; no overlap.
- IDLE, on accept: latch operands, then branch:
  - illegal -> RESP, illegal=1.
  - DIV with b=0 -> RESP, result 32'hFFFFFFFF; ALU not driven.
  - SLL/SRL with shamt=b[4:0]=0 -> RESP, result=a.
  - SLL/SRL otherwise -> SHIFT; alu_a=a, counter=shamt.
  - else -> EXEC; alu_a=a, alu_b (SRA: {27'b0,b[4:0]}), alu_sel loaded, counter = SETTLE_CYCLES or MULDIV_SETTLE.
- EXEC:
  - alu_* held stable; counter decrements each cycle.
  - At the cycle counter reaches 0, capture alu_out and alu_carry, go to RESP.
  - Latency: accept at edge T, rsp_valid from edge T+N.
- SHIFT:
  - Each cycle: capture alu_out into alu_a, decrement.
  - After shamt cycles, result = alu_a, go to RESP.
  - Settle is 1 per step; rsp_carry=0.
- RESP: rsp_* held stable while rsp_valid && !rsp_ready; on rsp_ready go to IDLE. A new request is accepted no earlier than the following cycle.
- rsp_zero is computed from the captured result, not from the ALU.

Optional Feature:
- MULDIV_EN defined: funct7=0000001 decodes MUL/DIV as above, including the div-by-zero shortcut.
- MULDIV_EN undefined: every funct7=0000001 request returns rsp_illegal=1, and alu_sel never takes 0010/0011.

Test Plan:
- ADD a=5, b=7, funct3=000, funct7=0, SETTLE=1 -> alu_sel=0000, rsp_result=12, rsp_zero=0, rsp_valid one cycle after EXEC entry.
- SUB a=3, b=5, funct7=0100000 -> rsp_result=32'hFFFFFFFE; SUB a=b=9 -> result 0, rsp_zero=1.
- SLL R-type a=1, b=37 (shamt 5) -> five SHIFT cycles, alu_sel=0100 each cycle, rsp_result=32.
- DIV (MULDIV_EN) a=10, b=0 -> rsp_result=32'hFFFFFFFF, no EXEC cycle, alu_sel unchanged. Without MULDIV_EN -> rsp_illegal=1, result 0.
- Backpressure: ADD result ready while rsp_ready is held low 3 cycles -> rsp_valid/rsp_result stable, req_ready=0, new req_valid not accepted until after the rsp handshake.
- Reset asserted during SHIFT (shamt=20, cycle 4) -> all outputs 0 immediately, no response after release, next ADD completes normally.
